booth_req_master: RTL and testbench

- Initiator-side sequencer for the booth multiplier's BREQ/BACK four-phase handshake.
- Buffers operand pairs in a small FIFO and issues one multiply at a time: it drives m1/m2/BREQ, waits for BACK, captures res, then completes the return-to-zero phase.
- Presents each product on a valid/ready output port.
- Sits between the FPU mantissa datapath and booth; replaces the hand-written drive sequences in bench tasks.

---
 rtl/booth_req_master.sv | 129 ++++++++++++
 tb/tb_booth_req_master.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_req_master.sv
// Initiator-side sequencer for the booth BREQ/BACK four-phase handshake.
// Buffers operand pairs, issues one multiply at a time, presents products on valid/ready.
module booth_req_master #(
  parameter int W       = 24,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic           CLK,
  input  logic           RSTN,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic [W-1:0]   m1,
  output logic [W-1:0]   m2,
  output logic           BREQ,
  input  logic           BACK,
  input  logic [2*W-1:0] res,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_data,
  output logic           busy,
  output logic           timeout_err,
  output logic [15:0]    job_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  fifo_a [DEPTH];
  logic [W-1:0]  fifo_b [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [TW-1:0] tmo_cnt;
  logic          push, pop, issue, capture, abort;

  assign in_ready = (count != (AW+1)'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = issue;
  assign busy     = (state != IDLE) || (count != '0);

  // Next-state: issue is gated on BACK low and an empty output register,
  // so a capture can never overwrite an unconsumed product.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    capture   = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if ((count != '0) && !BACK && !out_valid) begin
          issue     = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (BACK) begin
          capture   = 1'b1;
          state_nxt = RELEASE;
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          abort     = 1'b1;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (!BACK) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_a[wr_ptr] <= in_a;
      fifo_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      tmo_cnt     <= '0;
      BREQ        <= 1'b0;
      m1          <= '0;
      m2          <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      timeout_err <= 1'b0;
      job_count   <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      if (issue) begin
        m1      <= fifo_a[rd_ptr];
        m2      <= fifo_b[rd_ptr];
        BREQ    <= 1'b1;
        tmo_cnt <= '0;
      end else if ((state == REQ) && !BACK) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      if (capture || abort) BREQ <= 1'b0;
      if (abort) timeout_err <= 1'b1;

      if (capture) begin
        out_data  <= res;
        out_valid <= 1'b1;
        job_count <= job_count + 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_booth_req_master.sv
// Directed bench for booth_req_master: queued expected products checked by an output monitor,
// plus a behavioural booth responder with configurable ack delay and BACK hold.
module tb_booth_req_master;

  localparam int W = 24;

  logic           CLK = 1'b0;
  logic           RSTN = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_a = '0;
  logic [W-1:0]   in_b = '0;
  logic [W-1:0]   m1, m2;
  logic           BREQ;
  logic           BACK;
  logic [2*W-1:0] res;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] out_data;
  logic           busy;
  logic           timeout_err;
  logic [15:0]    job_count;

  booth_req_master #(.W(W), .DEPTH(4), .TIMEOUT(255)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .m1(m1), .m2(m2), .BREQ(BREQ), .BACK(BACK), .res(res),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .timeout_err(timeout_err), .job_count(job_count)
  );

  always #5 CLK = ~CLK;

  int             checks = 0;
  int             passes = 0;
  int             jobs_exp = 0;
  logic [2*W-1:0] exp_q [$];
  int             ack_delay = 1;
  int             ack_hold = 0;
  bit             resp_en = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic sig_val(input int which);
    case (which)
      0:       return BREQ;
      1:       return out_valid;
      default: return BACK;
    endcase
  endfunction

  task automatic wait_sig(input string name, input int which, input logic lvl, input int lim);
    int n = 0;
    while (sig_val(which) !== lvl && n < lim) begin
      tick();
      n++;
    end
    if (n >= lim) begin
      checks++;
      $display("FAIL %s: timed out after %0d cycles", name, lim);
    end
  endtask

  task automatic wait_drain(input string name, input int lim);
    int n = 0;
    while (exp_q.size() != 0 && n < lim) begin
      tick();
      n++;
    end
    if (n >= lim) begin
      checks++;
      $display("FAIL %s: %0d products still outstanding", name, exp_q.size());
    end
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2*W-1:0] p, input bit expect_out);
    int n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (!in_ready && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) begin
      checks++;
      $display("FAIL push_stall: in_ready stuck at %b", in_ready);
    end
    if (expect_out) begin
      exp_q.push_back(p);
      jobs_exp++;
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Booth responder: raises BACK ack_delay cycles after BREQ, keeps it ack_hold extra cycles.
  initial begin : responder
    int wcnt = 0;
    int hcnt = 0;
    BACK = 1'b0;
    res = '0;
    forever begin
      @(posedge CLK);
      #2;
      if (!RSTN) begin
        BACK = 1'b0;
        wcnt = 0;
        hcnt = 0;
      end else if (BREQ && !BACK) begin
        if (resp_en) begin
          wcnt++;
          if (wcnt >= ack_delay) begin
            BACK = 1'b1;
            res = {{W{1'b0}}, m1} * {{W{1'b0}}, m2};
            wcnt = 0;
          end
        end
      end else if (BACK && !BREQ) begin
        if (hcnt >= ack_hold) begin
          BACK = 1'b0;
          res = '0;
          hcnt = 0;
        end else begin
          hcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  always @(negedge CLK) begin
    if (RSTN && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_out: got %h with no product expected", out_data);
      end else begin
        check("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin : stimulus
    int n;
    int viol;
    int jobs_before;

    // Reset state
    tick();
    tick();
    check("rst_breq", BREQ, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_m1", m1, 0);
    check("rst_job_count", job_count, 0);
    check("rst_timeout_err", timeout_err, 0);
    RSTN = 1'b1;
    tick();

    // Single job, BACK 3 cycles after BREQ, output held until out_ready
    ack_delay = 3;
    push(24'hA00000, 24'hE00000, 48'h8C0000000000, 1'b1);
    wait_sig("t1_breq_rise", 0, 1'b1, 20);
    check("t1_m1", m1, 24'hA00000);
    check("t1_m2", m2, 24'hE00000);
    n = 0;
    while (BREQ === 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("t1_breq_high_cycles", n, 3);
    check("t1_out_valid", out_valid, 1);
    check("t1_out_data", out_data, 48'h8C0000000000);
    check("t1_job_count", job_count, 1);
    out_ready = 1'b1;
    wait_sig("t1_out_consumed", 1, 1'b0, 20);
    out_ready = 1'b0;
    check("t1_drained", exp_q.size(), 0);

    // Fill FIFO while output is blocked
    ack_delay = 1;
    jobs_before = jobs_exp;
    push(24'd2,  24'd3,  48'd6,   1'b1);
    push(24'd4,  24'd5,  48'd20,  1'b1);
    push(24'd6,  24'd7,  48'd42,  1'b1);
    push(24'd8,  24'd9,  48'd72,  1'b1);
    push(24'd10, 24'd11, 48'd110, 1'b1);
    check("t2_full_in_ready", in_ready, 0);
    in_valid = 1'b1;
    in_a = 24'd3;
    in_b = 24'd3;
    tick();
    in_valid = 1'b0;
    tick();
    check("t2_one_done", job_count, jobs_before + 1);
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      if (BREQ !== 1'b0) viol++;
      tick();
    end
    check("t2_breq_withheld", viol, 0);
    for (int i = 0; i < 5; i++) begin
      wait_sig("t2_pulse_wait", 1, 1'b1, 20);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    wait_drain("t2_drain", 50);
    check("t2_job_count", job_count, jobs_exp);

    // Extremes, continuous consumer
    out_ready = 1'b1;
    push(24'h000001, 24'h00FFFF, 48'h00000000FFFF, 1'b1);
    push(24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 1'b1);
    wait_drain("t3_drain", 50);
    check("t3_job_count", job_count, jobs_exp);

    // Timeout: responder silent for the first job
    resp_en = 1'b0;
    jobs_before = jobs_exp;
    push(24'd3, 24'd3, 48'd0, 1'b0);
    push(24'd5, 24'd5, 48'd25, 1'b1);
    wait_sig("t4_breq_rise", 0, 1'b1, 20);
    n = 0;
    while (BREQ === 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check("t4_req_cycles", n, 255);
    check("t4_timeout_err", timeout_err, 1);
    check("t4_no_out_valid", out_valid, 0);
    check("t4_no_count", job_count, jobs_before);
    resp_en = 1'b1;
    wait_drain("t4_drain", 50);
    check("t4_err_sticky", timeout_err, 1);
    check("t4_job_count", job_count, jobs_exp);

    // Responder holds BACK after BREQ falls
    ack_hold = 5;
    push(24'd7, 24'd6, 48'd42, 1'b1);
    push(24'd2, 24'd2, 48'd4, 1'b1);
    wait_sig("t5_breq_rise", 0, 1'b1, 20);
    wait_sig("t5_breq_fall", 0, 1'b0, 20);
    n = 0;
    viol = 0;
    while (BACK === 1'b1 && n < 50) begin
      if (BREQ !== 1'b0) viol++;
      tick();
      n++;
    end
    check("t5_no_breq_while_back", viol, 0);
    check("t5_hold_seen", n >= 5, 1);
    check("t5_release_still_low", BREQ, 0);
    wait_sig("t5_breq_rise2", 0, 1'b1, 20);
    check("t5_back_low_at_issue", BACK, 0);
    ack_hold = 0;
    wait_drain("t5_drain", 50);

    // Reset in the middle of a request
    resp_en = 1'b0;
    push(24'd1, 24'd1, 48'd0, 1'b0);
    push(24'd2, 24'd2, 48'd0, 1'b0);
    wait_sig("t6_breq_rise", 0, 1'b1, 20);
    #1;
    RSTN = 1'b0;
    #1;
    check("t6_breq", BREQ, 0);
    check("t6_out_valid", out_valid, 0);
    check("t6_job_count", job_count, 0);
    check("t6_in_ready", in_ready, 1);
    check("t6_busy", busy, 0);
    check("t6_timeout_err", timeout_err, 0);
    tick();
    RSTN = 1'b1;
    resp_en = 1'b1;
    viol = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (BREQ !== 1'b0) viol++;
    end
    check("t6_no_reissue", viol, 0);
    push(24'd3, 24'd5, 48'd15, 1'b1);
    wait_drain("t6_drain", 50);
    check("t6_job_count_after", job_count, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
